armleocpu_ptw_multilevel: RTL and testbench

Parametrised hardware page-table walker for the ArmleoCPU MMU. It sits between the TLB miss path and the Avalon-MM read port of the memory interconnect. It supports Sv32 (2 levels, 32-bit PTE) and Sv39 (3 levels, 64-bit PTE) through parameters. Beyond the fixed Sv32 walker, it adds:
- registered results;
- superpage alignment checks at every level;
- A-bit and reserved-bit checks;
- bare-mode passthrough;
- a walk abort with drain of in-flight reads.

---
 rtl/armleocpu_ptw_multilevel.sv | 200 ++++++++++++++++++++
 tb/tb_armleocpu_ptw_multilevel.sv | 482 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/armleocpu_ptw_multilevel.sv
// Multilevel page-table walker for the ArmleoCPU MMU (Sv32/Sv39).
// Single outstanding Avalon read; abort drains any read already in flight.
module armleocpu_ptw_multilevel #(
  parameter int LEVELS    = 2,
  parameter int VPN_BITS  = 10,
  parameter int PPN_BITS  = 22,
  parameter int PTE_BYTES = 4
) (
  input  logic                         clk,
  input  logic                         async_rst_n,
  output logic [PPN_BITS+12-1:0]       avl_address,
  output logic                         avl_read,
  input  logic [8*PTE_BYTES-1:0]       avl_readdata,
  input  logic                         avl_readdatavalid,
  input  logic                         avl_waitrequest,
  input  logic [1:0]                   avl_response,
  input  logic                         resolve_request,
  output logic                         resolve_ack,
  input  logic [LEVELS*VPN_BITS-1:0]   virtual_address,
  input  logic                         resolve_abort,
  output logic                         resolve_done,
  output logic                         resolve_pagefault,
  output logic                         resolve_accessfault,
  output logic [7:0]                   resolve_access_bits,
  output logic [PPN_BITS-1:0]          resolve_physical_address,
  output logic [1:0]                   resolve_level,
  input  logic                         matp_mode,
  input  logic [PPN_BITS-1:0]          matp_ppn
);

  localparam int PTE_W = 8 * PTE_BYTES;
  localparam int VA_W  = LEVELS * VPN_BITS;
  localparam int OFF_W = $clog2(PTE_BYTES);
  localparam logic [1:0] TOP = 2'(LEVELS - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ISSUE   = 3'd1;
  localparam logic [2:0] WAIT    = 3'd2;
  localparam logic [2:0] RESPOND = 3'd3;
  localparam logic [2:0] DRAIN   = 3'd4;

  logic [2:0]          state_q, state_d;
  logic [VA_W-1:0]     vpn_q, vpn_d;
  logic [PPN_BITS-1:0] base_q, base_d;
  logic [1:0]          lvl_q, lvl_d;
  logic                done_q, done_d;
  logic                pf_q, pf_d;
  logic                af_q, af_d;
  logic [PPN_BITS-1:0] pa_q, pa_d;
  logic [7:0]          bits_q, bits_d;
  logic [1:0]          rlvl_q, rlvl_d;

  logic [VPN_BITS-1:0] seg;
  logic [PPN_BITS-1:0] pte_ppn;
  logic [PPN_BITS-1:0] leaf_pa;
  logic [7:0]          fl;
  logic                misal;
  logic                rsvd;
  logic                bad;
  logic                is_leaf;
  logic [1:0]          unused_rsw;

  assign fl         = avl_readdata[7:0];
  assign pte_ppn    = avl_readdata[10 +: PPN_BITS];
  assign unused_rsw = avl_readdata[9:8];

  generate
    if (PTE_W > 10 + PPN_BITS) begin : g_rsvd
      assign rsvd = |avl_readdata[PTE_W-1:10+PPN_BITS];
    end else begin : g_no_rsvd
      assign rsvd = 1'b0;
    end
  endgenerate

  assign bad     = ~fl[0] | (~fl[1] & fl[2]) | rsvd;
  assign is_leaf = fl[1] | fl[3];

  always_comb begin
    seg = '0;
    for (int i = 0; i < LEVELS; i++)
      if (lvl_q == 2'(i))
        seg = vpn_q[i*VPN_BITS +: VPN_BITS];
  end

  // Superpage: low PPN segments must be zero and come from the VPN
  always_comb begin
    leaf_pa = pte_ppn;
    misal   = 1'b0;
    for (int i = 0; i < LEVELS - 1; i++)
      if (2'(i) < lvl_q) begin
        misal = misal | (|pte_ppn[i*VPN_BITS +: VPN_BITS]);
        leaf_pa[i*VPN_BITS +: VPN_BITS] = vpn_q[i*VPN_BITS +: VPN_BITS];
      end
  end

  assign avl_address = {base_q, seg, {OFF_W{1'b0}}};
  assign avl_read    = (state_q == ISSUE) && !resolve_abort;
  assign resolve_ack = (state_q == IDLE);

  assign resolve_done             = done_q;
  assign resolve_pagefault        = pf_q;
  assign resolve_accessfault      = af_q;
  assign resolve_access_bits      = bits_q;
  assign resolve_physical_address = pa_q;
  assign resolve_level            = rlvl_q;

  always_comb begin
    state_d = state_q;
    vpn_d   = vpn_q;
    base_d  = base_q;
    lvl_d   = lvl_q;
    pa_d    = pa_q;
    bits_d  = bits_q;
    rlvl_d  = rlvl_q;
    done_d  = 1'b0;
    pf_d    = 1'b0;
    af_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (resolve_request) begin
          vpn_d  = virtual_address;
          base_d = matp_ppn;
          lvl_d  = TOP;
          if (!matp_mode) begin
            state_d = RESPOND;
            done_d  = 1'b1;
            pa_d    = PPN_BITS'(virtual_address);
            bits_d  = 8'hDF;
            rlvl_d  = 2'd0;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (resolve_abort)         state_d = IDLE;
        else if (!avl_waitrequest) state_d = WAIT;
      end
      WAIT: begin
        if (resolve_abort) begin
          state_d = avl_readdatavalid ? IDLE : DRAIN;
        end else if (avl_readdatavalid) begin
          state_d = RESPOND;
          if (avl_response != 2'b00) begin
            af_d = 1'b1;
          end else if (bad) begin
            pf_d = 1'b1;
          end else if (is_leaf) begin
            if (misal || !fl[6]) begin
              pf_d = 1'b1;
            end else begin
              done_d = 1'b1;
              pa_d   = leaf_pa;
              bits_d = fl;
              rlvl_d = lvl_q;
            end
          end else if (lvl_q == 2'd0 || fl[4] || fl[6] || fl[7]) begin
            pf_d = 1'b1;
          end else begin
            base_d  = pte_ppn;
            lvl_d   = lvl_q - 2'd1;
            state_d = ISSUE;
          end
        end
      end
      RESPOND: state_d = IDLE;
      DRAIN: begin
        if (avl_readdatavalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_q <= IDLE;
      vpn_q   <= '0;
      base_q  <= '0;
      lvl_q   <= TOP;
      done_q  <= 1'b0;
      pf_q    <= 1'b0;
      af_q    <= 1'b0;
      pa_q    <= '0;
      bits_q  <= '0;
      rlvl_q  <= '0;
    end else begin
      state_q <= state_d;
      vpn_q   <= vpn_d;
      base_q  <= base_d;
      lvl_q   <= lvl_d;
      done_q  <= done_d;
      pf_q    <= pf_d;
      af_q    <= af_d;
      pa_q    <= pa_d;
      bits_q  <= bits_d;
      rlvl_q  <= rlvl_d;
    end
  end

endmodule

// File: tb/tb_armleocpu_ptw_multilevel.sv
// Bench for armleocpu_ptw_multilevel: Sv32 and Sv39 instances behind
// behavioural Avalon responders, results checked through a scoreboard.
module tb_armleocpu_ptw_multilevel;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int          kind;
    int          lat;
    logic [43:0] pa;
    logic [7:0]  bits;
    logic [1:0]  lvl;
  } exp_t;
  exp_t sb[$];

  // Sv32 instance
  logic [33:0] a_addr;
  logic        a_read;
  logic [31:0] a_rdata = '0;
  logic        a_rdv = 1'b0;
  logic        a_wr = 1'b0;
  logic [1:0]  a_resp = '0;
  logic        a_req = 1'b0;
  logic        a_ack;
  logic [19:0] a_va = '0;
  logic        a_abort = 1'b0;
  logic        a_done, a_pf, a_af;
  logic [7:0]  a_bits;
  logic [21:0] a_pa;
  logic [1:0]  a_lvl;
  logic        a_mode = 1'b1;
  logic [21:0] a_matp = 22'h00100;

  armleocpu_ptw_multilevel u_sv32 (
    .clk(clk), .async_rst_n(rst_n),
    .avl_address(a_addr), .avl_read(a_read),
    .avl_readdata(a_rdata), .avl_readdatavalid(a_rdv),
    .avl_waitrequest(a_wr), .avl_response(a_resp),
    .resolve_request(a_req), .resolve_ack(a_ack),
    .virtual_address(a_va), .resolve_abort(a_abort),
    .resolve_done(a_done), .resolve_pagefault(a_pf),
    .resolve_accessfault(a_af), .resolve_access_bits(a_bits),
    .resolve_physical_address(a_pa), .resolve_level(a_lvl),
    .matp_mode(a_mode), .matp_ppn(a_matp)
  );

  // Sv39 instance
  logic [55:0] b_addr;
  logic        b_read;
  logic [63:0] b_rdata = '0;
  logic        b_rdv = 1'b0;
  logic        b_wr = 1'b0;
  logic [1:0]  b_resp = '0;
  logic        b_req = 1'b0;
  logic        b_ack;
  logic [26:0] b_va = '0;
  logic        b_abort = 1'b0;
  logic        b_done, b_pf, b_af;
  logic [7:0]  b_bits;
  logic [43:0] b_pa;
  logic [1:0]  b_lvl;
  logic        b_mode = 1'b1;
  logic [43:0] b_matp = 44'h100;

  armleocpu_ptw_multilevel #(
    .LEVELS(3), .VPN_BITS(9), .PPN_BITS(44), .PTE_BYTES(8)
  ) u_sv39 (
    .clk(clk), .async_rst_n(rst_n),
    .avl_address(b_addr), .avl_read(b_read),
    .avl_readdata(b_rdata), .avl_readdatavalid(b_rdv),
    .avl_waitrequest(b_wr), .avl_response(b_resp),
    .resolve_request(b_req), .resolve_ack(b_ack),
    .virtual_address(b_va), .resolve_abort(b_abort),
    .resolve_done(b_done), .resolve_pagefault(b_pf),
    .resolve_accessfault(b_af), .resolve_access_bits(b_bits),
    .resolve_physical_address(b_pa), .resolve_level(b_lvl),
    .matp_mode(b_mode), .matp_ppn(b_matp)
  );

  // Sv32 memory: optional waitstates, fixed read latency, injectable error
  logic [31:0] mem_a [logic [33:0]];
  logic [33:0] a_seen[$];
  int          a_lat = 1;
  int          a_ws = 0;
  logic [1:0]  a_next_resp = 2'b00;
  int          a_stall = 0;
  int          a_cnt = 0;
  logic [31:0] a_pend = '0;
  logic [1:0]  a_pend_resp = '0;

  always @(negedge clk) begin
    a_rdv = 1'b0;
    if (a_cnt > 0) begin
      a_cnt--;
      if (a_cnt == 0) begin
        a_rdv = 1'b1;
        a_rdata = a_pend;
        a_resp = a_pend_resp;
      end
    end
    if (a_read && a_stall < a_ws) begin
      a_wr = 1'b1;
      a_stall++;
    end else begin
      a_wr = 1'b0;
    end
    if (!a_read) a_stall = 0;
    if (a_read && !a_wr) begin
      a_seen.push_back(a_addr);
      a_pend = mem_a.exists(a_addr) ? mem_a[a_addr] : 32'h0;
      a_pend_resp = a_next_resp;
      a_cnt = a_lat;
      a_stall = 0;
    end
  end

  logic [63:0] mem_b [logic [55:0]];
  int          b_cnt = 0;
  logic [63:0] b_pend = '0;

  always @(negedge clk) begin
    b_rdv = 1'b0;
    if (b_cnt > 0) begin
      b_cnt--;
      if (b_cnt == 0) begin
        b_rdv = 1'b1;
        b_rdata = b_pend;
      end
    end
    if (b_read) begin
      b_pend = mem_b.exists(b_addr) ? mem_b[b_addr] : 64'h0;
      b_cnt = 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic walk_a(input logic [19:0] va, input logic mode,
                        output int k, output int l);
    a_va = va;
    a_mode = mode;
    a_req = 1'b1;
    tick();
    a_req = 1'b0;
    l = 0;
    while (!(a_done | a_pf | a_af) && l < 40) begin
      tick();
      l++;
    end
    if ($countones({a_done, a_pf, a_af}) > 1) k = 9;
    else if (a_done) k = 1;
    else if (a_pf)   k = 2;
    else if (a_af)   k = 3;
    else             k = 0;
    tick();
  endtask

  task automatic walk_b(input logic [26:0] va, output int k, output int l);
    b_va = va;
    b_req = 1'b1;
    tick();
    b_req = 1'b0;
    l = 0;
    while (!(b_done | b_pf | b_af) && l < 40) begin
      tick();
      l++;
    end
    if ($countones({b_done, b_pf, b_af}) > 1) k = 9;
    else if (b_done) k = 1;
    else if (b_pf)   k = 2;
    else if (b_af)   k = 3;
    else             k = 0;
    tick();
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_chk++;
    if (a_ack !== 1'b1 || a_read !== 1'b0) begin
      n_fail++;
      $display("FAIL reset handshake: ack=%b read=%b want ack=1 read=0", a_ack, a_read);
    end
    n_chk++;
    if (a_addr !== 34'h0 || b_addr !== 56'h0) begin
      n_fail++;
      $display("FAIL reset address: a=%h b=%h want 0", a_addr, b_addr);
    end
    n_chk++;
    if ({a_done, a_pf, a_af, b_done, b_pf, b_af} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset pulses: %b%b%b want 000", a_done, a_pf, a_af);
    end
    n_chk++;
    if ({a_pa, a_bits, a_lvl} !== 32'h0) begin
      n_fail++;
      $display("FAIL reset results: pa=%h bits=%h lvl=%0d want 0", a_pa, a_bits, a_lvl);
    end
    n_chk++;
    if (b_ack !== 1'b1 || b_read !== 1'b0) begin
      n_fail++;
      $display("FAIL reset sv39: ack=%b read=%b want ack=1 read=0", b_ack, b_read);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_walk_4k();
    int k, l, base;
    exp_t e;
    mem_a[34'h0_0010_0120] = 32'h0008_0001;
    mem_a[34'h0_0020_0D14] = 32'h002A_F0CF;
    base = a_seen.size();
    sb.push_back('{kind: 1, lat: 4, pa: 44'hABC, bits: 8'hCF, lvl: 2'd0});
    walk_a(20'h12345, 1'b1, k, l);
    e = sb.pop_front();
    n_chk++;
    if (k !== e.kind || l !== e.lat) begin
      n_fail++;
      $display("FAIL walk4k pulse: kind=%0d lat=%0d want kind=%0d lat=%0d", k, l, e.kind, e.lat);
    end
    n_chk++;
    if ({22'd0, a_pa} !== e.pa || a_bits !== e.bits || a_lvl !== e.lvl) begin
      n_fail++;
      $display("FAIL walk4k result: pa=%h bits=%h lvl=%0d want pa=%h bits=%h lvl=%0d",
               a_pa, a_bits, a_lvl, e.pa, e.bits, e.lvl);
    end
    n_chk++;
    if (a_seen.size() != base + 2 || a_seen[base] !== 34'h0_0010_0120 ||
        a_seen[base+1] !== 34'h0_0020_0D14) begin
      n_fail++;
      $display("FAIL walk4k addresses: n=%0d first=%h want 2 reads 100120,200d14",
               a_seen.size() - base, a_seen[base]);
    end
  endtask

  task automatic test_superpage();
    int k, l;
    exp_t e;
    mem_a[34'h0_0010_0120] = 32'h0010_004B;
    sb.push_back('{kind: 1, lat: 2, pa: 44'h745, bits: 8'h4B, lvl: 2'd1});
    walk_a(20'h12345, 1'b1, k, l);
    e = sb.pop_front();
    n_chk++;
    if (k !== e.kind || l !== e.lat) begin
      n_fail++;
      $display("FAIL superpage pulse: kind=%0d lat=%0d want kind=%0d lat=%0d", k, l, e.kind, e.lat);
    end
    n_chk++;
    if ({22'd0, a_pa} !== e.pa || a_bits !== e.bits || a_lvl !== e.lvl) begin
      n_fail++;
      $display("FAIL superpage result: pa=%h bits=%h lvl=%0d want pa=%h bits=%h lvl=%0d",
               a_pa, a_bits, a_lvl, e.pa, e.bits, e.lvl);
    end
  endtask

  task automatic test_faults();
    logic [31:0] pt [5] = '{32'h0010_044B, 32'h0010_000B, 32'h0010_0005,
                            32'h0008_0011, 32'h0010_004B};
    logic [1:0]  rs [5] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
    int          kd [5] = '{2, 2, 2, 2, 3};
    int k, l;
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      mem_a[34'h0_0010_0120] = pt[i];
      a_next_resp = rs[i];
      sb.push_back('{kind: kd[i], lat: 2, pa: 44'h745, bits: 8'h4B, lvl: 2'd1});
      walk_a(20'h12345, 1'b1, k, l);
      a_next_resp = 2'b00;
      e = sb.pop_front();
      n_chk++;
      if (k !== e.kind || l !== e.lat) begin
        n_fail++;
        $display("FAIL fault[%0d] pulse: kind=%0d lat=%0d want kind=%0d lat=%0d",
                 i, k, l, e.kind, e.lat);
      end
      n_chk++;
      if ({22'd0, a_pa} !== e.pa || a_bits !== e.bits || a_lvl !== e.lvl) begin
        n_fail++;
        $display("FAIL fault[%0d] held result: pa=%h bits=%h lvl=%0d want pa=%h bits=%h lvl=%0d",
                 i, a_pa, a_bits, a_lvl, e.pa, e.bits, e.lvl);
      end
    end
  endtask

  task automatic test_abort_wait();
    int first, np, k, l;
    exp_t e;
    mem_a[34'h0_0010_0120] = 32'h0008_0001;
    a_lat = 4;
    a_va = 20'h12345;
    a_mode = 1'b1;
    a_req = 1'b1;
    tick();
    a_req = 1'b0;
    tick();
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
    np = (a_done | a_pf | a_af) ? 1 : 0;
    n_chk++;
    if (a_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_wait drain ack: ack=%b want 0", a_ack);
    end
    first = 0;
    for (int c = 4; c <= 10; c++) begin
      tick();
      if (a_done | a_pf | a_af) np++;
      if (a_ack && first == 0) first = c;
    end
    n_chk++;
    if (np != 0) begin
      n_fail++;
      $display("FAIL abort_wait pulses: got %0d want 0", np);
    end
    n_chk++;
    if (first != 6) begin
      n_fail++;
      $display("FAIL abort_wait idle cycle: got %0d want 6", first);
    end
    a_lat = 1;
    sb.push_back('{kind: 1, lat: 4, pa: 44'hABC, bits: 8'hCF, lvl: 2'd0});
    walk_a(20'h12345, 1'b1, k, l);
    e = sb.pop_front();
    n_chk++;
    if (k !== e.kind || l !== e.lat || {22'd0, a_pa} !== e.pa) begin
      n_fail++;
      $display("FAIL abort_wait next walk: kind=%0d lat=%0d pa=%h want kind=%0d lat=%0d pa=%h",
               k, l, a_pa, e.kind, e.lat, e.pa);
    end
  endtask

  task automatic test_abort_issue();
    int base, np;
    base = a_seen.size();
    a_ws = 5;
    a_va = 20'h12345;
    a_mode = 1'b1;
    a_req = 1'b1;
    tick();
    a_req = 1'b0;
    n_chk++;
    if (a_read !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_issue read before abort: read=%b want 1", a_read);
    end
    a_abort = 1'b1;
    #1;
    n_chk++;
    if (a_read !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_issue read drop: read=%b want 0", a_read);
    end
    tick();
    a_abort = 1'b0;
    a_ws = 0;
    n_chk++;
    if (a_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_issue idle: ack=%b want 1", a_ack);
    end
    np = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (a_done | a_pf | a_af | a_read) np++;
    end
    n_chk++;
    if (np != 0 || a_seen.size() != base) begin
      n_fail++;
      $display("FAIL abort_issue quiet: activity=%0d reads=%0d want 0 0",
               np, a_seen.size() - base);
    end
  endtask

  task automatic test_bare();
    int k, l;
    exp_t e;
    sb.push_back('{kind: 1, lat: 0, pa: 44'h12345, bits: 8'hDF, lvl: 2'd0});
    walk_a(20'h12345, 1'b0, k, l);
    e = sb.pop_front();
    n_chk++;
    if (k !== e.kind || l !== e.lat) begin
      n_fail++;
      $display("FAIL bare pulse: kind=%0d lat=%0d want kind=%0d lat=%0d", k, l, e.kind, e.lat);
    end
    n_chk++;
    if ({22'd0, a_pa} !== e.pa || a_bits !== e.bits || a_lvl !== e.lvl) begin
      n_fail++;
      $display("FAIL bare result: pa=%h bits=%h lvl=%0d want pa=%h bits=%h lvl=%0d",
               a_pa, a_bits, a_lvl, e.pa, e.bits, e.lvl);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] pat, ackp;
    a_va = 20'h0_0ABC;
    a_mode = 1'b0;
    a_req = 1'b1;
    tick();
    for (int c = 1; c <= 5; c++) begin
      pat[c-1] = a_done;
      ackp[c-1] = a_ack;
      if (c < 5) tick();
    end
    a_req = 1'b0;
    tick();
    n_chk++;
    if (pat !== 5'b10101) begin
      n_fail++;
      $display("FAIL back_to_back pulses: %b want 10101", pat);
    end
    n_chk++;
    if (ackp !== 5'b01010 || a_pa !== 22'h0_0ABC) begin
      n_fail++;
      $display("FAIL back_to_back ack/pa: ack=%b pa=%h want 01010 00abc", ackp, a_pa);
    end
  endtask

  task automatic test_sv39();
    int k, l;
    exp_t e;
    mem_b[56'h0010_0000] = 64'h0000_0000_1000_004F;
    sb.push_back('{kind: 1, lat: 2, pa: 44'h52345, bits: 8'h4F, lvl: 2'd2});
    walk_b(27'h0012345, k, l);
    e = sb.pop_front();
    n_chk++;
    if (k !== e.kind || l !== e.lat) begin
      n_fail++;
      $display("FAIL sv39 leaf pulse: kind=%0d lat=%0d want kind=%0d lat=%0d", k, l, e.kind, e.lat);
    end
    n_chk++;
    if (b_pa !== e.pa || b_bits !== e.bits || b_lvl !== e.lvl) begin
      n_fail++;
      $display("FAIL sv39 leaf result: pa=%h bits=%h lvl=%0d want pa=%h bits=%h lvl=%0d",
               b_pa, b_bits, b_lvl, e.pa, e.bits, e.lvl);
    end
    mem_b[56'h0010_0000] = 64'h1000_0000_1000_004F;
    sb.push_back('{kind: 2, lat: 2, pa: 44'h52345, bits: 8'h4F, lvl: 2'd2});
    walk_b(27'h0012345, k, l);
    e = sb.pop_front();
    n_chk++;
    if (k !== e.kind || l !== e.lat) begin
      n_fail++;
      $display("FAIL sv39 reserved pulse: kind=%0d lat=%0d want kind=%0d lat=%0d", k, l, e.kind, e.lat);
    end
    n_chk++;
    if (b_pa !== e.pa || b_lvl !== e.lvl) begin
      n_fail++;
      $display("FAIL sv39 held result: pa=%h lvl=%0d want pa=%h lvl=%0d", b_pa, b_lvl, e.pa, e.lvl);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_walk_4k();
    test_superpage();
    test_faults();
    test_abort_wait();
    test_abort_issue();
    test_bare();
    test_back_to_back();
    test_sv39();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
